// File: rtl/dnn_mac_seq.sv
// Time-multiplexed two-layer DNN: out = W2 * ReLU(W1 * x) on one shared signed MAC.
// Optional macro DNN_OUT_RELU_EN also clamps each output at zero.
module dnn_mac_seq #(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int DW    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*DW-1:0]        x,
  input  logic [N_IN*N_HID*DW-1:0]  w1,
  input  logic [N_HID*N_OUT*DW-1:0] w2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*(2*DW+$clog2(N_IN)+DW+$clog2(N_HID))-1:0] out,
  output logic                      busy
);

  localparam int HW   = 2*DW + $clog2(N_IN);
  localparam int OW   = HW + DW + $clog2(N_HID);
  localparam int CMAX = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                       : ((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  state_t                      state;
  logic [N_IN*DW-1:0]          x_r;
  logic [N_IN*N_HID*DW-1:0]    w1_r;
  logic [N_HID*N_OUT*DW-1:0]   w2_r;
  logic [N_HID*HW-1:0]         hid_r;
  logic signed [OW-1:0]        acc;
  logic [CW-1:0]               cnt_in;
  logic [CW-1:0]               cnt_out;

  logic signed [HW-1:0]        mac_a;
  logic signed [DW-1:0]        mac_b;
  logic signed [HW+DW-1:0]     prod;
  logic signed [OW-1:0]        acc_next;

  // cnt_in walks the fast index (i in L1, h in L2); cnt_out the slow one (h in L1, o in L2).
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    if (state == L2) begin
      mac_a = $signed(hid_r[int'(cnt_in)*HW +: HW]);
      mac_b = $signed(w2_r[(int'(cnt_out)*N_HID + int'(cnt_in))*DW +: DW]);
    end else begin
      mac_a = HW'($signed(x_r[int'(cnt_in)*DW +: DW]));
      mac_b = $signed(w1_r[(int'(cnt_out)*N_IN + int'(cnt_in))*DW +: DW]);
    end
    prod     = (HW+DW)'(mac_a) * (HW+DW)'(mac_b);
    acc_next = acc + OW'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
      x_r       <= '0;
      w1_r      <= '0;
      w2_r      <= '0;
      hid_r     <= '0;
      acc       <= '0;
      cnt_in    <= '0;
      cnt_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r      <= x;
            w1_r     <= w1;
            w2_r     <= w2;
            acc      <= '0;
            cnt_in   <= '0;
            cnt_out  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= L1;
          end
        end
        L1: begin
          if (cnt_in == CW'(N_IN-1)) begin
            hid_r[int'(cnt_out)*HW +: HW] <= acc_next[OW-1] ? '0 : acc_next[HW-1:0];
            acc    <= '0;
            cnt_in <= '0;
            if (cnt_out == CW'(N_HID-1)) begin
              cnt_out <= '0;
              state   <= L2;
            end else begin
              cnt_out <= cnt_out + CW'(1);
            end
          end else begin
            acc    <= acc_next;
            cnt_in <= cnt_in + CW'(1);
          end
        end
        L2: begin
          if (cnt_in == CW'(N_HID-1)) begin
`ifdef DNN_OUT_RELU_EN
            out[int'(cnt_out)*OW +: OW] <= acc_next[OW-1] ? '0 : acc_next;
`else
            out[int'(cnt_out)*OW +: OW] <= acc_next;
`endif
            acc    <= '0;
            cnt_in <= '0;
            if (cnt_out == CW'(N_OUT-1)) begin
              cnt_out   <= '0;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt_out <= cnt_out + CW'(1);
            end
          end else begin
            acc    <= acc_next;
            cnt_in <= cnt_in + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_mac_seq.sv
// Scoreboard bench for dnn_mac_seq: default instance (4-4-2, DW=5) and a 3-5-1, DW=8 instance.
module tb_dnn_mac_seq;

  localparam int LAT_A = 24;
  localparam int LAT_B = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_asrt = 0;
  int n_fail = 0;

  // Default-parameter instance
  logic        in_valid_a = 1'b0, out_ready_a = 1'b1;
  logic        in_ready_a, out_valid_a, busy_a;
  logic [19:0] x_a = '0;
  logic [79:0] w1_a = '0;
  logic [39:0] w2_a = '0;
  logic [37:0] out_a;

  dnn_mac_seq dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .x(x_a), .w1(w1_a), .w2(w2_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out(out_a), .busy(busy_a)
  );

  // N_IN=3, N_HID=5, N_OUT=1, DW=8 instance (OW=29)
  logic         in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic         in_ready_b, out_valid_b, busy_b;
  logic [23:0]  x_b = '0;
  logic [119:0] w1_b = '0;
  logic [39:0]  w2_b = '0;
  logic [28:0]  out_b;

  dnn_mac_seq #(.N_IN(3), .N_HID(5), .N_OUT(1), .DW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .x(x_b), .w1(w1_b), .w2(w2_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out(out_b), .busy(busy_b)
  );

  typedef struct { logic [37:0] v; int t; } exp_a_t;
  typedef struct { logic [28:0] v; int t; } exp_b_t;
  exp_a_t qa[$];
  exp_b_t qb[$];

  int xa[4], w1a[16], w2a[8], ea[2];
  int xb[3], w1b[15], w2b[5], eb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor A: compares on each rising out_valid, also latency and busy-cycle count.
  initial begin
    logic prev_v = 1'b0;
    int   busy_cnt = 0;
    exp_a_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) busy_cnt = 0;
      else if (busy_a) busy_cnt++;
      if (out_valid_a && !prev_v) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_out", out_a, e.v);
          chk("a_latency", cyc, e.t + LAT_A);
          chk("a_busy_cycles", busy_cnt, LAT_A);
        end
        busy_cnt = 0;
      end
      if (!out_valid_a && prev_v) chk("a_in_ready_after_done", in_ready_a, 1);
      prev_v = out_valid_a;
    end
  end

  initial begin
    logic prev_v = 1'b0;
    exp_b_t e;
    forever begin
      @(posedge clk); #1;
      if (out_valid_b && !prev_v) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_out", out_b, e.v);
          chk("b_latency", cyc, e.t + LAT_B);
        end
      end
      prev_v = out_valid_b;
    end
  end

  task automatic start_a();
    int n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 200) begin @(negedge clk); n++; end
    if (!in_ready_a) chk("a_ready_timeout", 0, 1);
    for (int i = 0; i < 4; i++)  x_a[i*5 +: 5]  = 5'(xa[i]);
    for (int i = 0; i < 16; i++) w1_a[i*5 +: 5] = 5'(w1a[i]);
    for (int i = 0; i < 8; i++)  w2_a[i*5 +: 5] = 5'(w2a[i]);
    in_valid_a = 1'b1;
    qa.push_back('{v: {19'(ea[1]), 19'(ea[0])}, t: cyc + 1});
    @(negedge clk);
    in_valid_a = 1'b0;
    chk("a_in_ready_low", in_ready_a, 0);
    chk("a_busy_high", busy_a, 1);
    x_a = ~x_a; w1_a = ~w1_a; w2_a = ~w2_a;
  endtask

  task automatic wait_a();
    int n = 0;
    while ((qa.size() != 0 || out_valid_a) && n < 300) begin @(negedge clk); n++; end
    if (qa.size() != 0 || out_valid_a) chk("a_done_timeout", 0, 1);
  endtask

  task automatic start_b();
    int n = 0;
    @(negedge clk);
    while (!in_ready_b && n < 200) begin @(negedge clk); n++; end
    if (!in_ready_b) chk("b_ready_timeout", 0, 1);
    for (int i = 0; i < 3; i++)  x_b[i*8 +: 8]  = 8'(xb[i]);
    for (int i = 0; i < 15; i++) w1_b[i*8 +: 8] = 8'(w1b[i]);
    for (int i = 0; i < 5; i++)  w2_b[i*8 +: 8] = 8'(w2b[i]);
    in_valid_b = 1'b1;
    qb.push_back('{v: 29'(eb), t: cyc + 1});
    @(negedge clk);
    in_valid_b = 1'b0;
    x_b = ~x_b; w1_b = ~w1_b; w2_b = ~w2_b;
  endtask

  task automatic wait_b();
    int n = 0;
    while ((qb.size() != 0 || out_valid_b) && n < 300) begin @(negedge clk); n++; end
    if (qb.size() != 0 || out_valid_b) chk("b_done_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_out", out_a, 0);
    rst_n = 1'b1;

    // all ones: hid=4, out=16
    xa = '{1, 1, 1, 1}; w1a = '{16{1}}; w2a = '{8{1}}; ea = '{16, 16};
    start_a(); wait_a();

    // negative W1 kills every hidden neuron
    w1a = '{16{-1}}; w2a = '{7, -3, 15, -16, 1, 2, -8, 9}; ea = '{0, 0};
    start_a(); wait_a();

    // extreme negatives: hid=1024, out=-65536
    xa = '{4{-16}}; w1a = '{16{-16}}; w2a = '{8{-16}};
`ifdef DNN_OUT_RELU_EN
    ea = '{0, 0};
`else
    ea = '{-65536, -65536};
`endif
    start_a(); wait_a();

    // mixed: hid=[4,0,4,3], out=[28,-27]
    xa  = '{1, 2, -3, 4};
    w1a = '{1, 1, 1, 1, -1, 0, 0, 0, 2, -1, 0, 1, 0, 0, -1, 0};
    w2a = '{1, 2, 3, 4, -2, 5, -1, -5};
`ifdef DNN_OUT_RELU_EN
    ea = '{28, 0};
`else
    ea = '{28, -27};
`endif
    start_a(); wait_a();

    // DONE held by out_ready=0 for 10 cycles, in_valid pulses ignored
    xa = '{1, 1, 1, 1}; w1a = '{16{1}}; w2a = '{8{1}}; ea = '{16, 16};
    out_ready_a = 1'b0;
    start_a();
    begin
      int n = 0;
      while (!out_valid_a && n < 100) begin @(negedge clk); n++; end
      chk("a_hold_reached", out_valid_a, 1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid_a = ~in_valid_a;
      chk("a_hold_out", out_a, {19'd16, 19'd16});
      chk("a_hold_in_ready", in_ready_a, 0);
      chk("a_hold_valid", out_valid_a, 1);
    end
    @(negedge clk);
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    chk("a_release_valid", out_valid_a, 0);
    chk("a_release_in_ready", in_ready_a, 1);
    chk("a_release_out_kept", out_a, {19'd16, 19'd16});
    repeat (3) @(negedge clk);
    chk("a_no_ghost_job", busy_a, 0);
    wait_a();

    // reset mid-L1 aborts the job
    xa = '{1, 2, -3, 4}; w1a = '{16{2}}; w2a = '{8{3}}; ea = '{0, 0};
    start_a();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("a_abort_valid", out_valid_a, 0);
    chk("a_abort_in_ready", in_ready_a, 1);
    chk("a_abort_busy", busy_a, 0);
    chk("a_abort_out", out_a, 0);
    qa.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // fresh job after abort: mixed vector with full latency
    xa  = '{1, 2, -3, 4};
    w1a = '{1, 1, 1, 1, -1, 0, 0, 0, 2, -1, 0, 1, 0, 0, -1, 0};
    w2a = '{1, 2, 3, 4, -2, 5, -1, -5};
`ifdef DNN_OUT_RELU_EN
    ea = '{28, 0};
`else
    ea = '{28, -27};
`endif
    start_a(); wait_a();

    // second configuration: hid=[60,0,0,110,2540], out=-325110
    xb  = '{10, -20, 30};
    w1b = '{1, 2, 3, -1, -1, -1, 5, 0, -2, 0, -4, 1, 127, 127, 127};
    w2b = '{2, 100, -100, -1, -128};
`ifdef DNN_OUT_RELU_EN
    eb = 0;
`else
    eb = -325110;
`endif
    start_b(); wait_b();

    // extremes: hid=49152 each, out=5*49152*(-128)
    xb = '{3{-128}}; w1b = '{15{-128}}; w2b = '{5{-128}};
`ifdef DNN_OUT_RELU_EN
    eb = 0;
`else
    eb = -31457280;
`endif
    start_b(); wait_b();

    // positive extreme: out=5*49152*127
    w2b = '{5{127}}; eb = 31211520;
    start_b(); wait_b();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
